// File: rtl/display_source_arbiter_if.sv
// Display source arbiter bus: control inputs, packed source buses and the
// registered display outputs, grouped for the board-level hookup.
interface display_source_arbiter_if #(
    parameter int N_SRC     = 4,
    parameter int SRC_IDX_W = 2,
    parameter int HOLD_W    = 4
);
    logic                   tick_1hz;
    logic                   frame_start;
    logic                   power_on;
    logic [SRC_IDX_W-1:0]   base_sel;
    logic [N_SRC-1:0]       ovl_req;
    logic                   ovl_cancel;
    logic [8*N_SRC-1:0]     src_digit1;
    logic [8*N_SRC-1:0]     src_digit2;
    logic [8*N_SRC-1:0]     src_tube_sel;
    logic [7:0]             digit1;
    logic [7:0]             digit2;
    logic [7:0]             tube_sel;
    logic [SRC_IDX_W-1:0]   active_src;
    logic                   ovl_active;
    logic [HOLD_W-1:0]      hold_left;

    modport master (
        output tick_1hz, frame_start, power_on, base_sel, ovl_req, ovl_cancel,
        output src_digit1, src_digit2, src_tube_sel,
        input  digit1, digit2, tube_sel, active_src, ovl_active, hold_left
    );

    modport slave (
        input  tick_1hz, frame_start, power_on, base_sel, ovl_req, ovl_cancel,
        input  src_digit1, src_digit2, src_tube_sel,
        output digit1, digit2, tube_sel, active_src, ovl_active, hold_left
    );
endinterface

// File: rtl/display_source_arbiter.sv
// Display source arbiter: picks one of N_SRC 7-segment sources for the board
// display, with a timed overlay, frame-aligned switching and power-off blanking.
module display_source_arbiter #(
    parameter int N_SRC      = 4,
    parameter int SRC_IDX_W  = 2,
    parameter int HOLD_TICKS = 5,
    parameter int HOLD_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    display_source_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        BLANK   = 2'd0,
        BASE    = 2'd1,
        OVERLAY = 2'd2
    } state_t;

    state_t               state;
    logic [SRC_IDX_W-1:0] ovl_idx;
    logic [SRC_IDX_W-1:0] active_src_q;
    logic [HOLD_W-1:0]    hold_left_q;
    logic                 ovl_active_q;
    logic [7:0]           digit1_q;
    logic [7:0]           digit2_q;
    logic [7:0]           tube_sel_q;

    logic [SRC_IDX_W-1:0] base_tgt;
    logic [SRC_IDX_W-1:0] req_idx;
    logic [SRC_IDX_W-1:0] target;
    logic                 any_req;

    // Out-of-range base selections fall back to source 0.
    always_comb begin
        base_tgt = bus.base_sel;
        if (int'(bus.base_sel) >= N_SRC) begin
            base_tgt = '0;
        end
    end

    // Lowest set overlay request bit wins.
    always_comb begin
        req_idx = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (bus.ovl_req[i-1]) begin
                req_idx = SRC_IDX_W'(i - 1);
            end
        end
    end

    assign any_req = |bus.ovl_req;

    // Source the display should show given the pre-edge state.
    always_comb begin
        target = base_tgt;
        if (state == OVERLAY) begin
            target = ovl_idx;
        end
    end

    // FSM, frame-aligned commit and registered display outputs.
    // power_on=0 is the only way into BLANK, so it also decides blanking of
    // the output registers on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= BLANK;
            ovl_idx      <= '0;
            active_src_q <= '0;
            hold_left_q  <= '0;
            ovl_active_q <= 1'b0;
            digit1_q     <= '0;
            digit2_q     <= '0;
            tube_sel_q   <= '0;
        end else begin
            if (state == BLANK || bus.frame_start) begin
                active_src_q <= target;
            end

            if (!bus.power_on) begin
                digit1_q   <= '0;
                digit2_q   <= '0;
                tube_sel_q <= '0;
            end else begin
                digit1_q   <= bus.src_digit1[{active_src_q, 3'b000} +: 8];
                digit2_q   <= bus.src_digit2[{active_src_q, 3'b000} +: 8];
                tube_sel_q <= bus.src_tube_sel[{active_src_q, 3'b000} +: 8];
            end

            if (!bus.power_on) begin
                state        <= BLANK;
                hold_left_q  <= '0;
                ovl_active_q <= 1'b0;
            end else begin
                case (state)
                    BLANK: begin
                        state <= BASE;
                    end
                    BASE: begin
                        if (any_req) begin
                            state        <= OVERLAY;
                            ovl_idx      <= req_idx;
                            hold_left_q  <= HOLD_W'(HOLD_TICKS);
                            ovl_active_q <= 1'b1;
                        end
                    end
                    OVERLAY: begin
                        if (bus.ovl_cancel) begin
                            state        <= BASE;
                            hold_left_q  <= '0;
                            ovl_active_q <= 1'b0;
                        end else if (any_req) begin
                            ovl_idx     <= req_idx;
                            hold_left_q <= HOLD_W'(HOLD_TICKS);
                        end else if (bus.tick_1hz) begin
                            if (hold_left_q > HOLD_W'(1)) begin
                                hold_left_q <= hold_left_q - HOLD_W'(1);
                            end else begin
                                state        <= BASE;
                                hold_left_q  <= '0;
                                ovl_active_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= BLANK;
                    end
                endcase
            end
        end
    end

    assign bus.digit1     = digit1_q;
    assign bus.digit2     = digit2_q;
    assign bus.tube_sel   = tube_sel_q;
    assign bus.active_src = active_src_q;
    assign bus.ovl_active = ovl_active_q;
    assign bus.hold_left  = hold_left_q;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed testbench for display_source_arbiter (N_SRC=4, 3-bit source index
// so an out-of-range base_sel can be exercised).
module tb_display_source_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    display_source_arbiter_if #(.N_SRC(4), .SRC_IDX_W(3), .HOLD_W(4)) dif ();

    display_source_arbiter #(
        .N_SRC(4),
        .SRC_IDX_W(3),
        .HOLD_TICKS(5),
        .HOLD_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        dif.frame_start = 1'b1;
        step();
        dif.frame_start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        dif.tick_1hz     = 1'b0;
        dif.frame_start  = 1'b0;
        dif.power_on     = 1'b0;
        dif.base_sel     = 3'd2;
        dif.ovl_req      = 4'b0000;
        dif.ovl_cancel   = 1'b0;
        dif.src_digit1   = {8'h13, 8'h12, 8'h11, 8'h10};
        dif.src_digit2   = {8'h23, 8'h22, 8'h21, 8'h20};
        dif.src_tube_sel = {8'h33, 8'h32, 8'h31, 8'h30};

        #3;
        check("rst_digit1", 32'(dif.digit1), 32'h0);
        check("rst_active_src", 32'(dif.active_src), 32'h0);
        check("rst_ovl_active", 32'(dif.ovl_active), 32'h0);
        check("rst_hold_left", 32'(dif.hold_left), 32'h0);

        step();
        rst = 1'b1;

        // Power off: BLANK tracks base_sel, display dark.
        step();
        step();
        check("blank_active_src", 32'(dif.active_src), 32'h2);
        check("blank_digit1", 32'(dif.digit1), 32'h0);

        // Power on with frame pulse: source 2 shown immediately.
        dif.power_on = 1'b1;
        pulse_frame();
        check("on_active_src", 32'(dif.active_src), 32'h2);
        check("on_digit1", 32'(dif.digit1), 32'h12);
        step();
        check("on_digit2", 32'(dif.digit2), 32'h22);
        check("on_tube_sel", 32'(dif.tube_sel), 32'h32);
        check("on_ovl_active", 32'(dif.ovl_active), 32'h0);

        // Frame-aligned switching.
        dif.base_sel = 3'd0;
        pulse_frame();
        check("sw0_active_src", 32'(dif.active_src), 32'h0);
        step();
        check("sw0_digit1", 32'(dif.digit1), 32'h10);
        dif.base_sel = 3'd1;
        for (int i = 0; i < 100; i++) step();
        check("noframe_active_src", 32'(dif.active_src), 32'h0);
        check("noframe_digit1", 32'(dif.digit1), 32'h10);
        pulse_frame();
        check("sw1_active_src", 32'(dif.active_src), 32'h1);
        check("sw1_digit1_lag", 32'(dif.digit1), 32'h10);
        step();
        check("sw1_digit1", 32'(dif.digit1), 32'h11);

        // Source data change shows after one cycle.
        dif.src_digit1 = {8'h13, 8'h12, 8'h55, 8'h10};
        step();
        check("src_latency", 32'(dif.digit1), 32'h55);
        dif.src_digit1 = {8'h13, 8'h12, 8'h11, 8'h10};

        // Overlay with timed expiry.
        dif.base_sel = 3'd3;
        pulse_frame();
        check("base3_active_src", 32'(dif.active_src), 32'h3);
        dif.ovl_req = 4'b0110;
        step();
        dif.ovl_req = 4'b0000;
        check("ovl_active_on", 32'(dif.ovl_active), 32'h1);
        check("ovl_hold_init", 32'(dif.hold_left), 32'h5);
        check("ovl_no_commit", 32'(dif.active_src), 32'h3);
        pulse_frame();
        check("ovl_active_src", 32'(dif.active_src), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            dif.tick_1hz = 1'b1;
            step();
            dif.tick_1hz = 1'b0;
            check($sformatf("tick%0d_hold", k), 32'(dif.hold_left), 32'(5 - k));
        end
        check("tick4_ovl_active", 32'(dif.ovl_active), 32'h1);
        dif.tick_1hz = 1'b1;
        step();
        dif.tick_1hz = 1'b0;
        check("tick5_hold", 32'(dif.hold_left), 32'h0);
        check("tick5_ovl_active", 32'(dif.ovl_active), 32'h0);
        pulse_frame();
        check("revert_active_src", 32'(dif.active_src), 32'h3);

        // Restart beats tick; cancel beats request.
        dif.base_sel = 3'd2;
        pulse_frame();
        check("base2_active_src", 32'(dif.active_src), 32'h2);
        dif.ovl_req = 4'b0001;
        step();
        dif.ovl_req = 4'b0000;
        dif.tick_1hz = 1'b1;
        step();
        step();
        dif.tick_1hz = 1'b0;
        check("pre_restart_hold", 32'(dif.hold_left), 32'h3);
        dif.ovl_req = 4'b1000;
        dif.tick_1hz = 1'b1;
        step();
        dif.ovl_req = 4'b0000;
        dif.tick_1hz = 1'b0;
        check("restart_hold", 32'(dif.hold_left), 32'h5);
        pulse_frame();
        check("restart_active_src", 32'(dif.active_src), 32'h3);
        dif.ovl_cancel = 1'b1;
        dif.ovl_req = 4'b0001;
        step();
        dif.ovl_cancel = 1'b0;
        dif.ovl_req = 4'b0000;
        check("cancel_ovl_active", 32'(dif.ovl_active), 32'h0);
        check("cancel_hold", 32'(dif.hold_left), 32'h0);
        pulse_frame();
        check("cancel_active_src", 32'(dif.active_src), 32'h2);

        // Power drop during overlay.
        dif.base_sel = 3'd1;
        dif.ovl_req = 4'b0100;
        step();
        dif.ovl_req = 4'b0000;
        pulse_frame();
        check("pwr_pre_active_src", 32'(dif.active_src), 32'h2);
        dif.power_on = 1'b0;
        step();
        check("pwr_off_digit1", 32'(dif.digit1), 32'h0);
        check("pwr_off_digit2", 32'(dif.digit2), 32'h0);
        check("pwr_off_tube_sel", 32'(dif.tube_sel), 32'h0);
        check("pwr_off_ovl_active", 32'(dif.ovl_active), 32'h0);
        check("pwr_off_hold", 32'(dif.hold_left), 32'h0);
        step();
        check("pwr_off_track", 32'(dif.active_src), 32'h1);
        dif.power_on = 1'b1;
        step();
        check("pwr_on_digit1", 32'(dif.digit1), 32'h11);
        check("pwr_on_ovl_active", 32'(dif.ovl_active), 32'h0);
        check("pwr_on_hold", 32'(dif.hold_left), 32'h0);

        // Asynchronous reset mid-cycle.
        #4;
        rst = 1'b0;
        #1;
        check("arst_digit1", 32'(dif.digit1), 32'h0);
        check("arst_tube_sel", 32'(dif.tube_sel), 32'h0);
        check("arst_active_src", 32'(dif.active_src), 32'h0);
        step();
        rst = 1'b1;

        // Out-of-range base selection clamps to source 0.
        dif.base_sel = 3'd7;
        dif.src_digit1 = {8'h13, 8'h12, 8'h11, 8'h77};
        step();
        check("clamp_active_src", 32'(dif.active_src), 32'h0);
        pulse_frame();
        check("clamp_frame_active_src", 32'(dif.active_src), 32'h0);
        step();
        check("clamp_digit1", 32'(dif.digit1), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/display_source_arbiter.md
Name: display_source_arbiter

Overview:
- Parametrised successor to the hood top-level's per-mode display multiplexer: selects one of N_SRC 7-segment sources (digit1/digit2/tube_sel) and drives the board display from a register.
- Adds a timed overlay: any source can request temporary display for HOLD_TICKS seconds, then the display reverts to the base source. Example use: accumulated-time readout on a button press.
- Source switches take effect only at scan-frame boundaries, so the display never tears mid-frame. Power-off blanking is built in.
- Sits between the smoker, currentTime and selfcleaner display outputs and the top-level digit/tube pins.

Parameters:
- N_SRC, 4, number of display sources (≥2).
- SRC_IDX_W, 2, width of a source index; 2^SRC_IDX_W ≥ N_SRC.
- HOLD_TICKS, 5, overlay duration in tick_1hz pulses (≥1).
- HOLD_W, 4, width of the hold counter; must hold HOLD_TICKS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- tick_1hz  in  1  single-cycle 1 Hz pulse, synchronous to clk.
- frame_start  in  1  single-cycle pulse at each scan-frame boundary.
- power_on  in  1  machine on/off state (level).
- base_sel  in  SRC_IDX_W  base source index, normally derived from mode_state.
- ovl_req  in  N_SRC  per-source overlay request pulses.
- ovl_cancel  in  1  pulse that ends an active overlay.
- src_digit1  in  8*N_SRC  source i occupies bits [8i+7:8i].
- src_digit2  in  8*N_SRC  same packing as src_digit1.
- src_tube_sel  in  8*N_SRC  same packing as src_digit1.
- digit1  out  8  registered segment output 1.
- digit2  out  8  registered segment output 2.
- tube_sel  out  8  registered tube select.
- active_src  out  SRC_IDX_W  committed source index.
- ovl_active  out  1  high while in OVERLAY.
- hold_left  out  HOLD_W  remaining overlay ticks; 0 outside OVERLAY.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BLANK.
  - digit1, digit2, tube_sel = 0; active_src = 0; ovl_active = 0; hold_left = 0.
- States: BLANK, BASE, OVERLAY.
- Priority each cycle, highest first: power_on=0 > ovl_cancel > ovl_req > tick_1hz.
- power_on=0:
  - From any state, next state is BLANK and hold_left is cleared.
  - Outputs are 0 from the next edge onward.
- BLANK → BASE on power_on=1.
- BASE:
  - target = base_sel. If base_sel ≥ N_SRC, target = 0.
  - Any ovl_req bit set → OVERLAY. ovl_idx = lowest set bit; hold_left = HOLD_TICKS.
- OVERLAY:
  - target = ovl_idx.
  - ovl_cancel → BASE, hold_left = 0. Cancel wins over a simultaneous ovl_req.
  - ovl_req → restart: new lowest set bit, hold_left reloaded. Request wins over a simultaneous tick.
  - tick_1hz with hold_left>1 → hold_left decrements.
  - tick_1hz with hold_left=1 → BASE, hold_left = 0.
- Commit rule:
  - On an edge where frame_start=1, active_src is loaded with the target computed from the pre-edge state.
  - Otherwise active_src holds.
  - In BLANK, active_src is loaded with the target on every edge, so the first lit frame after power-on is already correct.
- Output path, one-cycle registered:
  - If state (post-edge) is BLANK, digit1/digit2/tube_sel = 0.
  - Otherwise each output = the active_src slice of its source bus, sampled the same cycle.
  - Latency from a source input change to the output: 1 cycle.
- ovl_active = (state==OVERLAY), registered.
- Switching latency: worst case one frame period plus 1 cycle from the state change to the new source appearing.
- Mid-operation reset: immediate BLANK and zeroed outputs, with no dependence on frame_start.

Test Plan:
- Reset → power_on=1, base_sel=2, frame_start pulse → active_src=2; digit1 = src_digit1[23:16] one cycle later.
- BASE src0; base_sel changes to 1 with no frame_start for 100 cycles → active_src stays 0; first frame_start → active_src=1.
- ovl_req=4'b0110 in BASE → OVERLAY with ovl_idx=1, hold_left=5; 5 tick_1hz pulses → hold_left 4,3,2,1, then BASE; ovl_active falls on the 5th tick edge.
- In OVERLAY with hold_left=3, ovl_req=4'b1000 and tick_1hz in the same cycle → ovl_idx=3, hold_left=5. Next cycle, ovl_cancel together with ovl_req=4'b0001 → BASE.
- OVERLAY active and power_on drops → next edge: outputs 0, ovl_active=0, hold_left=0; power_on=1 → BASE with base_sel, and no overlay resumes.
- rst asserted asynchronously mid-frame (no clk edge) → all outputs 0 immediately; base_sel=7 with N_SRC=4 after power-on → active_src=0.
